instr_fetch_unit: RTL and testbench

- Sits directly downstream of the PC register. Consumes the current PC and fetches the instruction word from a variable-latency instruction memory over a valid/ready request and valid response interface.
- Presents the instruction plus its PC to decode with a valid/ready handshake.
- Drives pc_hold so the next-PC mux re-selects the current PC until the instruction is accepted.
- Detects misaligned PCs and memory timeouts.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_timeout_ctr.sv | 30 +++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and fault codes.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_t;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter for the fetch unit.
// expired flags the cycle in which the TIMEOUT-th counted cycle is being spent.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic startin,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (startin || clr) begin
            r_count <= '0;
        end else if (en && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The edge that closes the TIMEOUT-th busy cycle is the one that faults.
    assign expired = en && (r_count >= CNT_LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches the word at the current PC over a valid/ready
// memory port and holds it for decode, with misalignment and timeout faults.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              pc_hold,
    output logic              fault,
    output logic [1:0]        fault_code
);

    fetch_state_t      r_state;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic              r_inst_valid;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_fault;
    logic [1:0]        r_fault_code;
    logic              r_drain;

    logic w_start_ok;
    logic w_ctr_en;
    logic w_expired;

    assign w_start_ok = (r_state == IDLE) && fetch_en && (pc[1:0] == 2'b00);
    assign w_ctr_en   = (r_state == REQ) || (r_state == WAIT) || (r_state == DRAIN);

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .startin (startin),
        .clr     (w_start_ok),
        .en      (w_ctr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (startin) begin
            r_state         <= IDLE;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_inst_valid    <= 1'b0;
            r_inst          <= '0;
            r_inst_pc       <= '0;
            r_fault         <= 1'b0;
            r_fault_code    <= FLT_NONE;
            r_drain         <= 1'b0;
        end else if (w_expired) begin
            // Timeout wins over any coincident ready or response.
            r_state         <= FAULT;
            r_mem_req_valid <= 1'b0;
            r_inst_valid    <= 1'b0;
            r_fault         <= 1'b1;
            r_fault_code    <= FLT_TIMEOUT;
            r_drain         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_mem_req_addr  <= pc;
                        r_inst_pc       <= pc;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end else if (fetch_en) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= FLT_MISALIGN;
                        r_state      <= FAULT;
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_drain <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= (r_drain || flush) ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_inst       <= mem_rsp_data;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rsp_valid) begin
                        r_drain <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (flush || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign inst_valid    = r_inst_valid;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;

    // PC advances on acceptance; any live redirect loads the target.
    assign pc_hold = ~(((r_state == HOLD) && inst_ready && !flush) ||
                       (flush && (r_state != FAULT)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, misalign, timeout, flush and reset cases.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              startin = 1'b1;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              flush = 1'b0;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data = '0;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready = 1'b0;
    logic              pc_hold;
    logic              fault;
    logic [1:0]        fault_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .startin       (startin),
        .fetch_en      (fetch_en),
        .pc            (pc),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .pc_hold       (pc_hold),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        startin = 1'b1;
        tick();
        startin = 1'b0;
    endtask

    initial begin
        int stall_bad;

        tick();
        tick();
        startin = 1'b0;
        check_val("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check_val("rst_req_addr", 64'(mem_req_addr), 64'd0);
        check_val("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_val("rst_inst", 64'(inst), 64'd0);
        check_val("rst_inst_pc", 64'(inst_pc), 64'd0);
        check_val("rst_fault", 64'(fault), 64'd0);
        check_val("rst_fault_code", 64'(fault_code), 64'd0);
        check_val("rst_pc_hold", 64'(pc_hold), 64'd1);
        $display("txn reset: checks so far %0d", n_checks);

        // Zero-wait fetch at pc 0
        fetch_en = 1'b1; pc = 32'h0; mem_req_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        check_val("f1_req_valid", 64'(mem_req_valid), 64'd1);
        check_val("f1_req_addr", 64'(mem_req_addr), 64'd0);
        check_val("f1_c1_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        check_val("f1_c2_req_valid", 64'(mem_req_valid), 64'd0);
        check_val("f1_c2_inst_valid", 64'(inst_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2008_0005;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check_val("f1_c3_inst_valid", 64'(inst_valid), 64'd1);
        check_val("f1_inst", 64'(inst), 64'h2008_0005);
        check_val("f1_inst_pc", 64'(inst_pc), 64'd0);
        check_val("f1_hold_pc_hold", 64'(pc_hold), 64'd1);
        tick();
        check_val("f1_hold_stable_valid", 64'(inst_valid), 64'd1);
        check_val("f1_hold_stable_inst", 64'(inst), 64'h2008_0005);
        inst_ready = 1'b1;
        #1;
        check_val("f1_accept_pc_hold", 64'(pc_hold), 64'd0);
        tick();
        inst_ready = 1'b0;
        #1;
        check_val("f1_after_inst_valid", 64'(inst_valid), 64'd0);
        check_val("f1_after_pc_hold", 64'(pc_hold), 64'd1);
        check_val("f1_after_state", 64'(dut.r_state), 64'(IDLE));
        $display("txn fetch pc=0x0: inst=0x%0h", inst);

        // Misaligned PC
        fetch_en = 1'b1; pc = 32'h6;
        tick();
        fetch_en = 1'b0;
        check_val("mis_fault", 64'(fault), 64'd1);
        check_val("mis_fault_code", 64'(fault_code), 64'(FLT_MISALIGN));
        check_val("mis_req_valid", 64'(mem_req_valid), 64'd0);
        flush = 1'b1;
        #1;
        check_val("mis_flush_pc_hold", 64'(pc_hold), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b0;
        check_val("mis_persist_fault", 64'(fault), 64'd1);
        check_val("mis_persist_code", 64'(fault_code), 64'(FLT_MISALIGN));
        check_val("mis_persist_req_valid", 64'(mem_req_valid), 64'd0);
        do_reset();
        check_val("mis_clr_fault", 64'(fault), 64'd0);
        check_val("mis_clr_code", 64'(fault_code), 64'(FLT_NONE));
        $display("txn misaligned pc=0x6: fault cleared by reset");

        // Memory never ready: timeout after TIMEOUT busy cycles
        fetch_en = 1'b1; pc = 32'h100; mem_req_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        stall_bad = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || fault !== 1'b0)
                stall_bad++;
            tick();
        end
        check_val("to_stall_stable", 64'(stall_bad), 64'd0);
        check_val("to_last_req_valid", 64'(mem_req_valid), 64'd1);
        check_val("to_last_fault", 64'(fault), 64'd0);
        mem_req_ready = 1'b1;
        tick();
        check_val("to_fault", 64'(fault), 64'd1);
        check_val("to_fault_code", 64'(fault_code), 64'(FLT_TIMEOUT));
        check_val("to_req_valid", 64'(mem_req_valid), 64'd0);
        do_reset();
        $display("txn timeout pc=0x100: fault_code=%0d", 2);

        // Flush in WAIT, response two cycles later
        fetch_en = 1'b1; pc = 32'h40; mem_req_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check_val("fw_flush_pc_hold", 64'(pc_hold), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check_val("fw_drain_pc_hold", 64'(pc_hold), 64'd1);
        check_val("fw_drain_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check_val("fw_inst_valid", 64'(inst_valid), 64'd0);
        check_val("fw_inst", 64'(inst), 64'd0);
        check_val("fw_state", 64'(dut.r_state), 64'(IDLE));
        tick();
        check_val("fw_later_inst_valid", 64'(inst_valid), 64'd0);
        $display("txn flush-in-wait pc=0x40: response discarded");

        // Flush together with inst_ready in HOLD
        fetch_en = 1'b1; pc = 32'h80;
        tick();
        fetch_en = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check_val("fh_hold_inst", 64'(inst), 64'hCAFE_F00D);
        check_val("fh_hold_inst_pc", 64'(inst_pc), 64'h80);
        flush = 1'b1; inst_ready = 1'b1;
        #1;
        check_val("fh_pc_hold", 64'(pc_hold), 64'd0);
        tick();
        flush = 1'b0; inst_ready = 1'b0;
        check_val("fh_inst_valid", 64'(inst_valid), 64'd0);
        check_val("fh_state", 64'(dut.r_state), 64'(IDLE));
        $display("txn flush-in-hold pc=0x80: instruction dropped");

        // Flush in REQ while stalled: request still completes, response drained
        fetch_en = 1'b1; pc = 32'hC0; mem_req_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fr_req_valid_held", 64'(mem_req_valid), 64'd1);
        check_val("fr_req_addr_held", 64'(mem_req_addr), 64'hC0);
        mem_req_ready = 1'b1;
        tick();
        check_val("fr_req_valid_done", 64'(mem_req_valid), 64'd0);
        check_val("fr_state_drain", 64'(dut.r_state), 64'(DRAIN));
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check_val("fr_inst_valid", 64'(inst_valid), 64'd0);
        check_val("fr_inst_kept", 64'(inst), 64'hCAFE_F00D);
        check_val("fr_state_idle", 64'(dut.r_state), 64'(IDLE));
        $display("txn flush-in-req pc=0xc0: response drained");

        // Reset while in WAIT, late response ignored
        fetch_en = 1'b1; pc = 32'h200;
        tick();
        fetch_en = 1'b0;
        tick();
        startin = 1'b1;
        tick();
        startin = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check_val("rw_inst_valid", 64'(inst_valid), 64'd0);
        check_val("rw_inst", 64'(inst), 64'd0);
        check_val("rw_state", 64'(dut.r_state), 64'(IDLE));
        check_val("rw_pc_hold", 64'(pc_hold), 64'd1);
        $display("txn reset-in-wait pc=0x200: late response ignored");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
